// File: rtl/hyperbus_pkg.sv
// Shared types and helpers for the HyperBus RWDS window sampler.
// The sampled result, the sampler FSM state and the target half-cycle calculation.
package hyperbus_pkg;

    localparam int unsigned RwdsNumChips = 2;
    localparam int unsigned RwdsCsWidth  = $clog2(RwdsNumChips);

    typedef struct packed {
        logic                   value;
        logic                   unstable;
        logic [RwdsCsWidth-1:0] cs;
    } rwds_sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } rwds_smp_state_e;

    // Half-cycle index of the sampling edge. h=0 (rising half of the CS cycle) is never a target.
    function automatic logic [15:0] rwds_target_half(input logic [15:0] edge_idx,
                                                     input logic        edge_pol);
        logic [15:0] t;
        if (edge_pol) begin
            t = (edge_idx + 16'd1) << 1;
        end else begin
            t = (edge_idx << 1) + 16'd1;
        end
        return t;
    endfunction

endpackage

// File: rtl/hyperbus_rwds_window_chk.sv
// Evaluates both RWDS half-cycles of one clk_i cycle against the capture edge and
// stability window. value_o/unstable_o already include the current cycle's samples.
module hyperbus_rwds_window_chk #(
    parameter int unsigned CntWidth    = 6,
    parameter int unsigned HalfWidth   = CntWidth + 1,
    parameter int unsigned WindowWidth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   en_i,
    input  logic [CntWidth-1:0]    cnt_i,
    input  logic [HalfWidth-1:0]   target_i,
    input  logic [WindowWidth-1:0] window_i,
    input  logic [1:0]             rwds_ddr_i,
    output logic                   capture_o,
    output logic                   value_o,
    output logic                   unstable_o,
    output logic                   win_done_o
);

    logic [HalfWidth-1:0] h_rise, h_fall, last_half;
    logic                 cap_rise, cap_fall;
    logic                 in_win_rise, in_win_fall;
    logic                 base_value, base_unstable;
    logic                 value_q, unstable_q;

    assign h_rise    = {cnt_i, 1'b0};
    assign h_fall    = {cnt_i, 1'b1};
    assign last_half = target_i + HalfWidth'(window_i);

    assign in_win_rise = (h_rise >= target_i) && (h_rise <= last_half);
    assign in_win_fall = (h_fall >= target_i) && (h_fall <= last_half);

    assign cap_rise = en_i && (h_rise == target_i);
    assign cap_fall = en_i && (h_fall == target_i);

    // A new transfer must not inherit the previous transfer's capture.
    assign base_value    = start_i ? 1'b0 : value_q;
    assign base_unstable = start_i ? 1'b0 : unstable_q;

    always_comb begin
        value_o = base_value;
        if (cap_rise) begin
            value_o = rwds_ddr_i[0];
        end else if (cap_fall) begin
            value_o = rwds_ddr_i[1];
        end
    end

    assign unstable_o = base_unstable
                      | (en_i & in_win_rise & (rwds_ddr_i[0] != value_o))
                      | (en_i & in_win_fall & (rwds_ddr_i[1] != value_o));

    assign capture_o  = cap_rise | cap_fall;
    assign win_done_o = en_i && ((h_rise == last_half) || (h_fall == last_half));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q    <= 1'b0;
            unstable_q <= 1'b0;
        end else if (en_i) begin
            value_q    <= value_o;
            unstable_q <= unstable_o;
        end
    end

endmodule

// File: rtl/hyperbus_rwds_window_sampler.sv
// Counts RWDS half-cycles from CS assertion, captures RWDS at the configured edge,
// checks it over a stability window and hands the result to the PHY FSM via valid/ready.
module hyperbus_rwds_window_sampler
    import hyperbus_pkg::*;
#(
    parameter int unsigned NumChips     = RwdsNumChips,
    parameter int unsigned EdgeIdxWidth = 4,
    parameter int unsigned WindowWidth  = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [EdgeIdxWidth-1:0]     cfg_edge_idx_i,
    input  logic                        cfg_edge_pol_i,
    input  logic [WindowWidth-1:0]      cfg_window_i,
    input  logic [NumChips-1:0]         hyper_cs_ni,
    input  logic [1:0]                  rwds_ddr_i,
    output logic                        sample_valid_o,
    input  logic                        sample_ready_i,
    output logic                        rwds_sample_o,
    output logic [$clog2(NumChips)-1:0] sample_cs_o,
    output logic                        sample_unstable_o,
    output logic                        active_o
);

    localparam int unsigned CsWidth   = $clog2(NumChips);
    localparam int unsigned CntWidth  = EdgeIdxWidth + 2;
    localparam int unsigned HalfWidth = CntWidth + 1;

    rwds_smp_state_e state_q, state_d;

    logic [CntWidth-1:0]  cnt_q, cnt_d, cnt_eval;
    logic                 conflict_q, conflict_d, conflict_now;
    logic                 captured_q, captured_d;
    logic [CsWidth-1:0]   cs_sel_q, cs_sel_d, cs_now;
    rwds_sample_t         result_q, result_d;

    logic [NumChips-1:0]  cs_low;
    logic                 any_low, multi_low;
    logic [CsWidth-1:0]   low_idx;
    logic                 start, eval, finish;
    logic [HalfWidth-1:0] target_half;

    logic chk_capture, chk_value, chk_unstable, chk_win_done;

    assign cs_low    = ~hyper_cs_ni;
    assign any_low   = |cs_low;
    assign multi_low = |(cs_low & (cs_low - NumChips'(1)));

    always_comb begin
        low_idx = '0;
        for (int i = NumChips - 1; i >= 0; i--) begin
            if (cs_low[i]) begin
                low_idx = CsWidth'(i);
            end
        end
    end

    assign target_half = HalfWidth'(rwds_target_half(16'(cfg_edge_idx_i), cfg_edge_pol_i));

    // Cycle k=0 is evaluated in IDLE, the cycle CS is first seen low.
    assign start    = (state_q == IDLE) && any_low;
    assign eval     = start || ((state_q == COUNT) && any_low);
    assign cnt_eval = start ? '0 : cnt_q;
    // The window end never precedes the capture edge, so the guard only blocks stale state.
    assign finish   = eval && chk_win_done && (chk_capture || (captured_q && !start));

    hyperbus_rwds_window_chk #(
        .CntWidth    (CntWidth),
        .HalfWidth   (HalfWidth),
        .WindowWidth (WindowWidth)
    ) u_window_chk (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start),
        .en_i       (eval),
        .cnt_i      (cnt_eval),
        .target_i   (target_half),
        .window_i   (cfg_window_i),
        .rwds_ddr_i (rwds_ddr_i),
        .capture_o  (chk_capture),
        .value_o    (chk_value),
        .unstable_o (chk_unstable),
        .win_done_o (chk_win_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_low) begin
                    state_d = finish ? HOLD : COUNT;
                end
            end
            COUNT: begin
                if (!any_low) begin
                    state_d = IDLE;
                end else if (finish) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (sample_ready_i) begin
                    state_d = any_low ? DONE : IDLE;
                end
            end
            DONE: begin
                if (!any_low) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_valid_o = (state_q == HOLD);
        active_o       = (state_q == COUNT);
    end

    assign conflict_now = start ? multi_low : (conflict_q | multi_low);
    assign cs_now       = start ? low_idx : cs_sel_q;

    always_comb begin
        cnt_d      = '0;
        conflict_d = conflict_q;
        captured_d = captured_q;
        cs_sel_d   = cs_now;
        result_d   = result_q;
        if (state_d == COUNT) begin
            cnt_d = start ? CntWidth'(1) : ((&cnt_q) ? cnt_q : cnt_q + CntWidth'(1));
        end
        if (eval) begin
            conflict_d = conflict_now;
            captured_d = (captured_q && !start) || chk_capture;
        end
        if (state_d == IDLE) begin
            conflict_d = 1'b0;
            captured_d = 1'b0;
        end
        if (finish) begin
            result_d.value    = chk_value;
            result_d.unstable = chk_unstable | conflict_now;
            result_d.cs       = cs_now;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            conflict_q <= 1'b0;
            captured_q <= 1'b0;
            cs_sel_q   <= '0;
            result_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
            captured_q <= captured_d;
            cs_sel_q   <= cs_sel_d;
            result_q   <= result_d;
        end
    end

    assign rwds_sample_o     = result_q.value;
    assign sample_unstable_o = result_q.unstable;
    assign sample_cs_o       = result_q.cs;

endmodule

// File: tb/tb_hyperbus_rwds_window_sampler.sv
// Scoreboard bench for the RWDS window sampler: expected results are computed from the
// driven RWDS half-cycle pattern and popped when sample_valid_o appears.
module tb_hyperbus_rwds_window_sampler;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] cfg_edge_idx;
    logic       cfg_edge_pol;
    logic [1:0] cfg_window;
    logic [1:0] hyper_cs_n;
    logic [1:0] rwds_ddr;
    logic       sample_valid;
    logic       sample_ready;
    logic       rwds_sample;
    logic       sample_cs;
    logic       sample_unstable;
    logic       active;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic value;
        logic unstable;
        logic cs;
        int   lat;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    hyperbus_rwds_window_sampler dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .cfg_edge_idx_i    (cfg_edge_idx),
        .cfg_edge_pol_i    (cfg_edge_pol),
        .cfg_window_i      (cfg_window),
        .hyper_cs_ni       (hyper_cs_n),
        .rwds_ddr_i        (rwds_ddr),
        .sample_valid_o    (sample_valid),
        .sample_ready_i    (sample_ready),
        .rwds_sample_o     (rwds_sample),
        .sample_cs_o       (sample_cs),
        .sample_unstable_o (sample_unstable),
        .active_o          (active)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_valid"},    sample_valid,    0);
        check_val({tag, "_active"},   active,          0);
        check_val({tag, "_sample"},   rwds_sample,     0);
        check_val({tag, "_cs"},       sample_cs,       0);
        check_val({tag, "_unstable"}, sample_unstable, 0);
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    // bits[h] is RWDS at half-cycle h counted from the first CS-low cycle.
    task automatic run_xfer(input logic [3:0] idx, input logic pol, input logic [1:0] win,
                            input logic [1:0] mask, input logic [79:0] bits, input bit hold);
        int   t, last, k_seen;
        bit   seen;
        exp_t e, g;
        cfg_edge_idx = idx;
        cfg_edge_pol = pol;
        cfg_window   = win;
        t    = pol ? 2 * (int'(idx) + 1) : 2 * int'(idx) + 1;
        last = t + int'(win);
        e.value    = bits[t];
        e.unstable = (mask == 2'b11);
        for (int h = t; h <= last; h++) begin
            if (bits[h] != bits[t]) e.unstable = 1'b1;
        end
        e.cs  = mask[0] ? 1'b0 : 1'b1;
        e.lat = last / 2 + 1;
        sb_q.push_back(e);
        sample_ready = hold ? 1'b0 : 1'b1;
        seen   = 1'b0;
        k_seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            hyper_cs_n = ~mask;
            rwds_ddr   = {bits[2*k+1], bits[2*k]};
            cycle();
            if (sample_valid) begin
                seen   = 1'b1;
                k_seen = k + 1;
            end
        end
        check_val("valid_seen", seen, 1);
        if (sb_q.size() > 0) begin
            g = sb_q.pop_front();
            if (seen) begin
                check_val("value",    rwds_sample,     g.value);
                check_val("unstable", sample_unstable, g.unstable);
                check_val("cs_idx",   sample_cs,       g.cs);
                check_val("latency",  k_seen,          g.lat);
            end
        end
        if (!hold) begin
            hyper_cs_n = 2'b11;
            cycle();
            check_val("post_valid",  sample_valid, 0);
            check_val("post_active", active,       0);
            sample_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni       = 1'b0;
        hyper_cs_n   = 2'b11;
        rwds_ddr     = 2'b00;
        sample_ready = 1'b0;
        cfg_edge_idx = 4'd0;
        cfg_edge_pol = 1'b0;
        cfg_window   = 2'd0;
        cycle();
        cycle();
        check_outputs_zero("reset");
        rst_ni = 1'b1;
        cycle();

        // T=4, RWDS high over h=3..5
        run_xfer(4'd1, 1'b1, 2'd0, 2'b01, 80'h38, 1'b0);
        // T=1, window to h=3, RWDS drops at h=3
        run_xfer(4'd0, 1'b0, 2'd2, 2'b10, 80'h06, 1'b0);
        // T=1, window 0: done within the first CS cycle
        run_xfer(4'd0, 1'b0, 2'd0, 2'b01, 80'h02, 1'b0);
        // largest target T=32, full window
        run_xfer(4'd15, 1'b1, 2'd3, 2'b10, 80'hF_0000_0000, 1'b0);

        // abort: T=8, CS released in cycle k=2
        cfg_edge_idx = 4'd3;
        cfg_edge_pol = 1'b1;
        cfg_window   = 2'd0;
        hyper_cs_n   = 2'b10;
        rwds_ddr     = 2'b11;
        cycle();
        check_val("abort_active_k0", active, 1);
        cycle();
        hyper_cs_n = 2'b11;
        cycle();
        check_val("abort_active", active, 0);
        check_val("abort_valid",  sample_valid, 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_val("abort_idle_valid", sample_valid, 0);
        end

        // valid held without ready while CS toggles; T=5, window to h=6
        run_xfer(4'd2, 1'b0, 2'd1, 2'b01, 80'h60, 1'b1);
        for (int i = 0; i < 10; i++) begin
            hyper_cs_n   = (i % 2 == 0) ? 2'b11 : 2'b10;
            rwds_ddr     = 2'($urandom_range(0, 3));
            sample_ready = 1'b0;
            cycle();
            check_val("hold_valid",    sample_valid,    1);
            check_val("hold_value",    rwds_sample,     1);
            check_val("hold_unstable", sample_unstable, 0);
            check_val("hold_cs",       sample_cs,       0);
        end
        hyper_cs_n   = 2'b10;
        sample_ready = 1'b1;
        cycle();
        check_val("hs_valid", sample_valid, 0);
        sample_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rwds_ddr = 2'($urandom_range(0, 3));
            cycle();
            check_val("done_valid",  sample_valid, 0);
            check_val("done_active", active,       0);
        end
        hyper_cs_n = 2'b11;
        cycle();

        // both chips selected: lowest index wins, flagged unstable
        run_xfer(4'd0, 1'b1, 2'd0, 2'b11, 80'h0, 1'b0);

        // reset mid-COUNT
        cfg_edge_idx = 4'd3;
        cfg_edge_pol = 1'b1;
        hyper_cs_n   = 2'b01;
        cycle();
        cycle();
        check_val("rc_active", active, 1);
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("rst_count");
        hyper_cs_n = 2'b11;
        cycle();
        rst_ni = 1'b1;
        cycle();

        // reset mid-HOLD
        run_xfer(4'd1, 1'b1, 2'd0, 2'b10, 80'h10, 1'b1);
        rst_ni = 1'b0;
        #1;
        check_outputs_zero("rst_hold");
        hyper_cs_n = 2'b11;
        cycle();
        rst_ni = 1'b1;
        cycle();

        // restart from k=0 after reset: T=3, window to h=6, RWDS drops at h=5
        run_xfer(4'd1, 1'b0, 2'd3, 2'b10, 80'h58, 1'b0);

        check_val("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hyperbus_rwds_window_sampler.md
Name: hyperbus_rwds_window_sampler

Overview:
Synchronous, multi-chip successor to the gated-clock RWDS sampler. It runs entirely in the PHY clock domain. It takes the DDR-registered RWDS samples (rising and falling half-cycle per clk_i cycle) and counts half-cycles from CS assertion. At a configurable edge it captures RWDS and checks it for stability over a configurable window of following half-cycles. The result, the active chip index and a stability flag go to the PHY FSM over a valid/ready handshake.

Parameters:
NumChips, 2, number of hyper_cs_ni lines monitored
EdgeIdxWidth, 4, width of cfg_edge_idx_i
WindowWidth, 2, width of cfg_window_i; window length = cfg_window_i+1 half-cycles (max 4)

Ports:
clk_i  in  1  PHY clock
rst_ni  in  1  asynchronous active-low reset
cfg_edge_idx_i  in  EdgeIdxWidth  sampling edge number (pseudostatic)
cfg_edge_pol_i  in  1  1: rising, 0: falling (pseudostatic)
cfg_window_i  in  WindowWidth  extra half-cycles checked for stability (pseudostatic)
hyper_cs_ni  in  NumChips  chip selects, active low, synchronous to clk_i
rwds_ddr_i  in  2  [0]=RWDS at rising half of cycle, [1]=at falling half
sample_valid_o  out  1  result available
sample_ready_i  in  1  PHY FSM accepts result
rwds_sample_o  out  1  RWDS value at target edge
sample_cs_o  out  $clog2(NumChips)  index of selected chip
sample_unstable_o  out  1  RWDS changed inside window, or several CS low
active_o  out  1  transfer being tracked (state COUNT)

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0.
- Half-cycle index h: cycle k=0 is the first cycle any CS is low. rwds_ddr_i[0] is h=2k, rwds_ddr_i[1] is h=2k+1.
- Target T = cfg_edge_pol_i ? 2*(cfg_edge_idx_i+1) : 2*cfg_edge_idx_i+1. idx=0/pol=0 is the first falling half (h=1). idx=0/pol=1 is h=2. h=0 is never sampled.
- Window covers h in [T, T+cfg_window_i]. The captured value is the sample at h=T. unstable = OR over the window of (sample != captured).
- Cycle counter width EdgeIdxWidth+2. It saturates at all-ones. The last window index always fits, so saturation only occurs after the window.
- States:
  - IDLE: any CS low -> COUNT. Latch sample_cs_o = lowest low index. Set the conflict flag if more than one CS is low. Process k=0 samples in the same cycle.
  - COUNT: increment the counter each cycle and evaluate both halves each cycle. When the window completes, go to HOLD. All CS high before completion (abort) -> IDLE; no valid, flags cleared.
  - HOLD: sample_valid_o=1. Outputs are stable until sample_ready_i. On handshake: if all CS high -> IDLE, else -> DONE.
  - DONE: wait for all CS high -> IDLE.
- Latency: sample_valid_o rises the cycle after the clk_i cycle containing half-cycle T+cfg_window_i.
- Conflict: more than one CS low at any time in COUNT sets the unstable flag. Selection stays on the latched index.
- CS deassert and reassert while in HOLD: that new transfer is not sampled. Counting restarts only from IDLE with CS sampled low.
- A valid must never drop without ready. rwds_sample_o, sample_cs_o and sample_unstable_o change only when entering HOLD.

Decomposition:
- hyperbus_pkg gets:
  - typedef rwds_sample_t {logic value; logic unstable; logic [$clog2(NumChips)-1:0] cs;}
  - the state enum rwds_smp_state_e {IDLE, COUNT, HOLD, DONE}
  - function rwds_target_half() computing T.
- One sub-module, hyperbus_rwds_window_chk:
  - inputs: counter, T, window length, rwds_ddr_i
  - outputs: capture strobe, captured value, running unstable flag, window-done
  - uses the same clock and reset.

Test Plan:
1. idx=1, pol=1, window=0. CS0 falls, RWDS=1 from h=3 to h=5 -> T=4, valid in cycle k=3, rwds_sample_o=1, sample_cs_o=0, unstable=0.
2. idx=0, pol=0, window=2. CS1 low, RWDS 1 at h=1,2, then 0 at h=3 -> value=1, unstable=1, sample_cs_o=1, valid at cycle k=2.
3. idx=3, pol=1 (T=8). CS raised at cycle k=2 -> no valid, active_o falls next cycle, state IDLE.
4. Valid pending, ready held low 10 cycles, CS toggled high/low -> outputs frozen. Handshake, then IDLE, no second valid for the toggled transfer.
5. CS0 and CS1 low together, idx=0, pol=1 -> sample_cs_o=0, unstable=1.
6. rst_ni asserted mid-COUNT and mid-HOLD -> all outputs 0 immediately. The next CS fall restarts from k=0.
